// File: rtl/range_loader.sv
`timescale 1ns/1ps
// range_loader: turns an ASCII stream of "low-high" lines into range FIFO writes.
// Each good line becomes one FIFO word. Malformed lines and lines with low > high are
// dropped and counted. A blank line ends the range section and parks the block in DONE.
//
// Input handshake: a byte moves when in_valid && in_ready on a rising range_clk edge.
// in_valid may be raised or dropped on any cycle. in_ready is low only while a parsed
// range is waiting for FIFO space, and during rst.
module range_loader #(
   parameter int ADDR_W = 17,
   parameter int CNT_W  = 16
) (
   input  logic              range_clk,
   input  logic              rst,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              fifo_full,
   output logic              wr_en,
   output logic [ADDR_W-1:0] input_range_low,
   output logic [ADDR_W-1:0] input_range_high,
   output logic              input_range_fresh,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  range_count,
   output logic [CNT_W-1:0]  drop_count
);

   localparam int ACC_W = ADDR_W + 4;

   typedef enum logic [2:0] {
      S_LOW  = 3'd0,
      S_HIGH = 3'd1,
      S_EMIT = 3'd2,
      S_SKIP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] acc, acc_next;
   logic [ADDR_W-1:0] low_q, low_next;
   logic              seen_digit, seen_next;
   logic              accept;
   logic              is_digit, is_dash, is_lf, is_cr;
   logic [ACC_W-1:0]  acc_wide;
   logic              acc_ovf;
   logic              bad_line;
   logic              out_load;
   logic              set_done, set_err;
   logic              drop_inc, range_inc;

   assign in_ready          = (state != S_EMIT) && !rst;
   assign wr_en             = (state == S_EMIT) && !fifo_full && !rst;
   assign input_range_fresh = 1'b1;
   assign accept            = in_valid && in_ready;

   assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
   assign is_dash  = (in_byte == 8'h2D);
   assign is_lf    = (in_byte == 8'h0A);
   assign is_cr    = (in_byte == 8'h0D);

   // Extra headroom bits so one digit step can never wrap; anything above ADDR_W bits is overflow.
   assign acc_wide = (ACC_W'(acc) * ACC_W'(10)) + ACC_W'(in_byte[3:0]);
   assign acc_ovf  = |acc_wide[ACC_W-1:ADDR_W];

   // Next-state and datapath control for the line parser
   always_comb begin
      state_next = state;
      acc_next   = acc;
      seen_next  = seen_digit;
      low_next   = low_q;
      out_load   = 1'b0;
      set_done   = 1'b0;
      set_err    = 1'b0;
      drop_inc   = 1'b0;
      range_inc  = 1'b0;
      bad_line   = 1'b0;
      case (state)
         S_LOW: begin
            if (accept && !is_cr) begin
               if (is_digit) begin
                  if (acc_ovf) begin
                     bad_line = 1'b1;
                  end else begin
                     acc_next  = acc_wide[ADDR_W-1:0];
                     seen_next = 1'b1;
                  end
               end else if (is_dash && seen_digit) begin
                  low_next   = acc;
                  acc_next   = '0;
                  seen_next  = 1'b0;
                  state_next = S_HIGH;
               end else if (is_lf && !seen_digit) begin
                  set_done   = 1'b1;
                  state_next = S_DONE;
               end else begin
                  bad_line = 1'b1;
               end
            end
         end
         S_HIGH: begin
            if (accept && !is_cr) begin
               if (is_digit) begin
                  if (acc_ovf) begin
                     bad_line = 1'b1;
                  end else begin
                     acc_next  = acc_wide[ADDR_W-1:0];
                     seen_next = 1'b1;
                  end
               end else if (is_lf && seen_digit) begin
                  acc_next  = '0;
                  seen_next = 1'b0;
                  if (low_q <= acc) begin
                     out_load   = 1'b1;
                     state_next = S_EMIT;
                  end else begin
                     drop_inc   = 1'b1;
                     state_next = S_LOW;
                  end
               end else begin
                  bad_line = 1'b1;
               end
            end
         end
         S_EMIT: begin
            if (wr_en) begin
               range_inc  = 1'b1;
               state_next = S_LOW;
            end
         end
         S_SKIP: begin
            if (accept && is_lf) begin
               state_next = S_LOW;
            end
         end
         S_DONE: begin
            state_next = S_DONE;
         end
         default: begin
            state_next = S_LOW;
         end
      endcase
      // A bad byte ends the line; if it was the newline itself there is nothing left to skip.
      if (bad_line) begin
         set_err    = 1'b1;
         drop_inc   = 1'b1;
         acc_next   = '0;
         seen_next  = 1'b0;
         state_next = is_lf ? S_LOW : S_SKIP;
      end
   end

   // Parser state register
   always_ff @(posedge range_clk) begin
      if (rst) begin
         state <= S_LOW;
      end else begin
         state <= state_next;
      end
   end

   // Accumulators, output range registers, sticky flags and saturating counters
   always_ff @(posedge range_clk) begin
      if (rst) begin
         acc              <= '0;
         low_q            <= '0;
         seen_digit       <= 1'b0;
         input_range_low  <= '0;
         input_range_high <= '0;
         done             <= 1'b0;
         err              <= 1'b0;
         range_count      <= '0;
         drop_count       <= '0;
      end else begin
         acc        <= acc_next;
         low_q      <= low_next;
         seen_digit <= seen_next;
         if (out_load) begin
            input_range_low  <= low_q;
            input_range_high <= acc;
         end
         if (set_done) begin
            done <= 1'b1;
         end
         if (set_err) begin
            err <= 1'b1;
         end
         if (range_inc && (range_count != '1)) begin
            range_count <= range_count + CNT_W'(1);
         end
         if (drop_inc && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/range_loader.md
# range_loader

Write-side producer for the freshness-check design. It consumes the puzzle's range section as an ASCII byte stream, one `low-high` line per range. It parses each line into two ADDR_W-bit unsigned integers and pushes each range as a single word into the range FIFO. It drives the FIFO's write interface (`wr_en`, `input_range_low`, `input_range_high`, `input_range_fresh`) and honours the FIFO's full flag. It signals completion when the blank line that ends the range section arrives.

## Interface
- ADDR_W, 17, width of range bounds and of the FIFO data fields
- CNT_W, 16, width of the range/drop counters
- range_clk  in  1  write-domain clock; all logic is on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_byte  in  8  ASCII input character
- in_valid  in  1  in_byte is valid this cycle
- in_ready  out  1  block accepts in_byte this cycle; a transfer happens when in_valid && in_ready
- fifo_full  in  1  range FIFO full flag (same clock domain)
- wr_en  out  1  FIFO write strobe, at most one cycle per range
- input_range_low  out  ADDR_W  range lower bound, inclusive
- input_range_high  out  ADDR_W  range upper bound, inclusive
- input_range_fresh  out  1  constant 1 whenever wr_en=1
- done  out  1  sticky; blank line seen
- err  out  1  sticky; at least one malformed or overflowing line
- range_count  out  CNT_W  ranges written to the FIFO
- drop_count  out  CNT_W  lines discarded (error or low>high)

## Operation
- States:
  - LOW: accumulating the low bound
  - HIGH: accumulating the high bound
  - EMIT: holding a parsed range for the FIFO
  - SKIP: discarding the rest of a bad line
  - DONE: terminal until reset
- Accumulator update per digit '0'..'9': acc <= acc*10 + digit, computed at ADDR_W+4 bits. If the result exceeds 2^ADDR_W-1, the line is bad.
- '\r' (0x0D) is ignored in every state.
- LOW:
  - digit: accumulate, set seen_digit.
  - '-' with seen_digit: latch low, clear acc, go to HIGH.
  - '\n' with no digit and no pending chars: set done, go to DONE.
  - any other byte: line is bad.
- HIGH:
  - digit: accumulate.
  - '\n' with at least one digit: latch high, then
    - if low<=high, go to EMIT;
    - else drop_count++ and return to LOW (not an error).
  - any other byte, or '\n' with no digit: line is bad.
- Bad line:
  - set err, drop_count++.
  - If the offending byte is '\n', return to LOW; otherwise go to SKIP.
  - SKIP discards bytes until '\n', then returns to LOW.
- EMIT:
  - in_ready=0.
  - wr_en = (state==EMIT) && !fifo_full && !rst.
  - On the cycle wr_en=1: range_count++, go to LOW.
- DONE: in_ready=1; all bytes are consumed and ignored.
- Counters saturate at 2^CNT_W-1.
- input_range_low/high are registered. They are stable for the whole EMIT dwell and hold their last value afterwards.

## Timing
- Reset values:
  - in_ready=0 during rst, 1 on the first cycle after.
  - wr_en=0, input_range_low=0, input_range_high=0, input_range_fresh=1.
  - done=0, err=0, range_count=0, drop_count=0; state LOW, acc=0.
- in_ready=1 in LOW/HIGH/SKIP/DONE and 0 in EMIT. Throughput is one byte per cycle.
- Latency: '\n' accepted at cycle N → EMIT at N+1 → wr_en=1 at N+1 if fifo_full=0 at N+1. The next byte is accepted at N+2 at the earliest.
- fifo_full=1 in EMIT:
  - wr_en stays 0 and data holds.
  - wr_en asserts on the first cycle fifo_full=0.
  - fifo_full may toggle arbitrarily; exactly one write occurs per range.
- done rises the cycle after the blank-line '\n' is accepted. err rises the cycle after the bad byte is accepted.
- rst mid-EMIT: wr_en=0 in the rst cycle itself. The pending range is lost; no partial write.
- rst mid-line: the partial accumulators are discarded.
- Max values: a bound of 2^ADDR_W-1 is legal. One more is overflow.

## Test plan
- ADDR_W=17, stream "20-24\n6-8\n\n", fifo_full=0 → wr_en pulses twice, with (20,24,1) then (6,8,1). Then done=1, range_count=2, err=0.
- Same stream with fifo_full=1 for 5 cycles after the first '\n' → in_ready=0 and wr_en=0 for those cycles, data held at (20,24). One write occurs on the release cycle; the second range and done follow normally.
- "131071-131071\n131072-5\n" → one write (131071,131071); then err=1, drop_count=1, range_count=1.
- "9-3\n4-4\n" → the first line is dropped (drop_count=1, err=0). Then the write (4,4) occurs.
- "1x-5\n7-9\r\n" → err=1, the rest of line 1 is skipped, drop_count=1. The write (7,9) occurs ('\r' ignored).
- rst asserted for 1 cycle while in EMIT with fifo_full=1 → no wr_en ever for that range. All outputs return to reset values. "2-3\n" afterwards writes (2,3) with range_count=1.
